// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-through bypass and a post-reset
// clear sequencer that zeroes one entry per cycle before raising ready.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_RD*ADDR_W-1:0]   RDaddr_i,
    output logic [NUM_RD*DATA_W-1:0]   RDdata_o,
    input  logic                       WRen_i,
    input  logic [ADDR_W-1:0]          WRaddr_i,
    input  logic [DATA_W-1:0]          WRdata_i,
    output logic                       ready_o,
    output logic [ADDR_W-1:0]          clr_cnt_o
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam bit          ZERO_EN = (ZERO_REG != 0);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_drop_c;

    assign wr_drop_c = ZERO_EN && (WRaddr_i == '0);

    // Clear sequencer and array write; reset leaves the array alone and the
    // sequencer re-zeroes it afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= CLEAR;
            clr_cnt_o <= '0;
            ready_o   <= 1'b0;
        end else if (state == CLEAR) begin
            mem[clr_cnt_o] <= '0;
            clr_cnt_o      <= clr_cnt_o + ADDR_W'(1);
            if (clr_cnt_o == ADDR_W'(DEPTH - 1)) begin
                state   <= RUN;
                ready_o <= 1'b1;
            end
        end else if (WRen_i && !wr_drop_c) begin
            mem[WRaddr_i] <= WRdata_i;
        end
    end

    // Independent read ports: CLEAR forces zero, then zero register, then bypass.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_word;

        assign rd_addr = RDaddr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_word = mem[rd_addr];
            if (state == CLEAR) begin
                rd_word = '0;
            end else if (ZERO_EN && (rd_addr == '0)) begin
                rd_word = '0;
            end else if (WRen_i && (WRaddr_i == rd_addr)) begin
                rd_word = WRdata_i;
            end
        end

        assign RDdata_o[k*DATA_W +: DATA_W] = rd_word;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default 32x32/2-port instance plus a
// 8x16/4-port instance; expectations queued by stimulus, checked by a monitor.
module tb_regfile_mp;

    localparam int unsigned SIG_RD_A  = 0;
    localparam int unsigned SIG_RDY_A = 1;
    localparam int unsigned SIG_CNT_A = 2;
    localparam int unsigned SIG_RD_B  = 3;
    localparam int unsigned SIG_RDY_B = 4;

    typedef struct {
        string       name;
        int unsigned sig;
        int unsigned port;
        logic [31:0] exp;
    } exp_t;

    logic         clk;
    logic         rst_a, rst_b;
    logic [9:0]   ra_a;
    logic [63:0]  rd_a;
    logic         we_a;
    logic [4:0]   wa_a;
    logic [31:0]  wd_a;
    logic         rdy_a;
    logic [4:0]   cnt_a;

    logic [11:0]  ra_b;
    logic [63:0]  rd_b;
    logic         we_b;
    logic [2:0]   wa_b;
    logic [15:0]  wd_b;
    logic         rdy_b;
    logic [2:0]   cnt_b;

    exp_t q[$];
    int   checks;
    int   failures;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .RDaddr_i(ra_a), .RDdata_o(rd_a),
        .WRen_i(we_a), .WRaddr_i(wa_a), .WRdata_i(wd_a),
        .ready_o(rdy_a), .clr_cnt_o(cnt_a)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .RDaddr_i(ra_b), .RDdata_o(rd_b),
        .WRen_i(we_b), .WRaddr_i(wa_b), .WRdata_i(wd_b),
        .ready_o(rdy_b), .clr_cnt_o(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sample(input int unsigned sig, input int unsigned port);
        case (sig)
            SIG_RD_A:  return rd_a[port*32 +: 32];
            SIG_RDY_A: return 32'(rdy_a);
            SIG_CNT_A: return 32'(cnt_a);
            SIG_RD_B:  return 32'(rd_b[port*16 +: 16]);
            SIG_RDY_B: return 32'(rdy_b);
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: drain all pending expectations mid-cycle, away from the edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = q.pop_front();
            act = sample(e.sig, e.port);
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic push(input string name, input int unsigned sig,
                        input int unsigned port, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.port = port;
        e.exp  = val;
        q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input int unsigned p0, input int unsigned p1);
        ra_a = {5'(p1), 5'(p0)};
    endtask

    // Called right after reset is released on dut_a; walks the 32-edge clear.
    task automatic run_clear(input bit chk_b, input bit write_mid);
        push("clr_start_ready", SIG_RDY_A, 0, 32'd0);
        push("clr_start_cnt",   SIG_CNT_A, 0, 32'd0);
        push("clr_start_rd0",   SIG_RD_A,  0, 32'd0);
        cycle();
        for (int k = 1; k <= 32; k++) begin
            we_a = write_mid && (k == 5);
            wa_a = 5'd3;
            wd_a = 32'h0000_00AA;
            set_ra(0, 3);
            push($sformatf("clr_ready_k%0d", k), SIG_RDY_A, 0, (k == 32) ? 32'd1 : 32'd0);
            push($sformatf("clr_cnt_k%0d", k),   SIG_CNT_A, 0, 32'(k % 32));
            if (k < 32)
                push($sformatf("clr_rd1_k%0d", k), SIG_RD_A, 1, 32'd0);
            if (chk_b)
                push($sformatf("b_ready_k%0d", k), SIG_RDY_B, 0, (k >= 8) ? 32'd1 : 32'd0);
            cycle();
        end
        we_a = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        ra_a = '0; we_a = 1'b0; wa_a = '0; wd_a = '0;
        ra_b = '0; we_b = 1'b0; wa_b = '0; wd_b = '0;

        cycle();
        rst_a = 1'b0; rst_b = 1'b0;
        run_clear(1'b1, 1'b0);

        // Every entry reads zero after clear.
        for (int i = 0; i < 16; i++) begin
            set_ra(i, i + 16);
            push($sformatf("zero_a%0d", i),      SIG_RD_A, 0, 32'd0);
            push($sformatf("zero_a%0d", i + 16), SIG_RD_A, 1, 32'd0);
            cycle();
        end

        // Array write then read on both ports, including the last entry.
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEAD_BEEF; set_ra(6, 6);
        push("wr5_other", SIG_RD_A, 0, 32'd0);
        cycle();
        wa_a = 5'd31; wd_a = 32'h0BAD_F00D; set_ra(5, 5);
        push("rd5_p0", SIG_RD_A, 0, 32'hDEAD_BEEF);
        push("rd5_p1", SIG_RD_A, 1, 32'hDEAD_BEEF);
        cycle();
        we_a = 1'b0; set_ra(31, 5);
        push("rd31", SIG_RD_A, 0, 32'h0BAD_F00D);
        cycle();

        // Same-cycle bypass on port 1 only, then via array.
        we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h1234_5678; set_ra(6, 7);
        push("byp7_p0_unaff", SIG_RD_A, 0, 32'd0);
        push("byp7_p1",       SIG_RD_A, 1, 32'h1234_5678);
        cycle();
        we_a = 1'b1; wa_a = 5'd9; wd_a = 32'hCAFE_F00D; set_ra(9, 9);
        push("byp9_p0",  SIG_RD_A, 0, 32'hCAFE_F00D);
        push("byp9_p1",  SIG_RD_A, 1, 32'hCAFE_F00D);
        cycle();
        we_a = 1'b0; set_ra(9, 7);
        push("arr9",  SIG_RD_A, 0, 32'hCAFE_F00D);
        push("arr7",  SIG_RD_A, 1, 32'h1234_5678);
        cycle();

        // Entry 0 stays zero: no bypass, no store.
        we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFF_FFFF; set_ra(0, 5);
        push("zr_same",  SIG_RD_A, 0, 32'd0);
        push("zr_other", SIG_RD_A, 1, 32'hDEAD_BEEF);
        cycle();
        we_a = 1'b0; set_ra(0, 0);
        push("zr_later_p0", SIG_RD_A, 0, 32'd0);
        push("zr_later_p1", SIG_RD_A, 1, 32'd0);
        cycle();

        // Four-port instance: fill 1..7, read odd entries on all ports.
        for (int i = 1; i <= 7; i++) begin
            we_b = 1'b1; wa_b = 3'(i); wd_b = 16'(16'h1111 * i);
            cycle();
        end
        we_b = 1'b0;
        ra_b = {3'd7, 3'd5, 3'd3, 3'd1};
        push("b_rd_p0", SIG_RD_B, 0, 32'h1111);
        push("b_rd_p1", SIG_RD_B, 1, 32'h3333);
        push("b_rd_p2", SIG_RD_B, 2, 32'h5555);
        push("b_rd_p3", SIG_RD_B, 3, 32'h7777);
        cycle();
        we_b = 1'b1; wa_b = 3'd6; wd_b = 16'hA5A5; ra_b = {3'd6, 3'd6, 3'd0, 3'd6};
        push("b_byp_p0",  SIG_RD_B, 0, 32'hA5A5);
        push("b_zero_p1", SIG_RD_B, 1, 32'h0000);
        push("b_byp_p3",  SIG_RD_B, 3, 32'hA5A5);
        cycle();
        we_b = 1'b0;

        // Reset from RUN, abort the clear at clr_cnt=10, then full re-clear.
        rst_a = 1'b1;
        cycle();
        rst_a = 1'b0;
        for (int i = 1; i < 10; i++) cycle();
        cycle();
        push("mid_cnt10", SIG_CNT_A, 0, 32'd10);
        rst_a = 1'b1;
        cycle();
        push("mid_rst_cnt",   SIG_CNT_A, 0, 32'd0);
        push("mid_rst_ready", SIG_RDY_A, 0, 32'd0);
        cycle();
        rst_a = 1'b0;
        run_clear(1'b0, 1'b1);

        set_ra(3, 5);
        push("lost_wr3", SIG_RD_A, 0, 32'd0);
        push("reclr5",   SIG_RD_A, 1, 32'd0);
        cycle();
        set_ra(31, 9);
        push("reclr31", SIG_RD_A, 0, 32'd0);
        push("reclr9",  SIG_RD_A, 1, 32'd0);
        cycle();
        cycle();

        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
